// File: rtl/lake_fifo_pkg.sv
// Shared definitions for the LakeTop input buffer.
// Address-width helper, pointer type and reset data value.
package lake_fifo_pkg;

   function automatic int lake_addr_w(input int depth);
      return $clog2(depth);
   endfunction

   localparam int LAKE_DEPTH_DFLT = 4;
   localparam int LAKE_AW_DFLT = lake_addr_w(LAKE_DEPTH_DFLT);

   // Pointer layout: {wrap, addr}; the wrap bit tells full from empty.
   typedef logic [LAKE_AW_DFLT:0] lake_ptr_t;

   localparam int LAKE_RST_DATA = 0;

endpackage

// File: rtl/lake_fifo_mem.sv
// Storage array for the LakeTop input buffer.
// One write port and one asynchronous read port; the array has no reset.
module lake_fifo_mem
   import lake_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int AW = lake_addr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Capture the incoming word at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lake_in_fifo.sv
// First-word-fall-through ready/valid buffer feeding the LakeTop lanes.
// Define LAKE_IN_FIFO_COUNT_EN to expose the occupancy port o_count.
module lake_in_fifo
   import lake_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_valid,
   input  logic                  i_ready
`ifdef LAKE_IN_FIFO_COUNT_EN
   ,
   output logic [lake_addr_w(DEPTH):0] o_count
`endif
);

   localparam int AW = lake_addr_w(DEPTH);

   typedef logic [AW:0] ptr_t;

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;

   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  we;
   logic [DATA_WIDTH-1:0] rdata;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // Flags come from registered pointers only, so i_ready never reaches o_ready.
   assign o_ready = !full;
   assign o_valid = !empty;

   assign push = i_valid && o_ready;
   assign pop  = o_valid && i_ready;
   assign we   = push && !flush;

   // Advance pointers on handshakes; flush wins and discards both.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         end
      end
   end

   // Pointer state; reset empties the buffer immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   lake_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (i_data_in),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rdata)
   );

   // Hold a known value on the bus when nothing is stored.
   assign o_data_out = empty ? DATA_WIDTH'(LAKE_RST_DATA) : rdata;

`ifdef LAKE_IN_FIFO_COUNT_EN
   assign o_count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_lake_in_fifo.sv
// Bench for lake_in_fifo: directed steps plus random traffic
// checked against a queue-based model of the buffer.
module tb_lake_in_fifo;

   localparam int DW = 2;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [DW-1:0] i_data_in;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] o_data_out;
   logic          o_valid;
   logic          i_ready;
`ifdef LAKE_IN_FIFO_COUNT_EN
   logic [$clog2(DEPTH):0] o_count;
`endif

   int total;
   int bad;
   logic [DW-1:0] q [$];

   lake_in_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .i_data_in  (i_data_in),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_data_out (o_data_out),
      .o_valid    (o_valid),
      .i_ready    (i_ready)
`ifdef LAKE_IN_FIFO_COUNT_EN
      ,
      .o_count    (o_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_head();
      return (q.size() > 0) ? q[0] : '0;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(o_valid), 32'(q.size() > 0));
      chk({tag, ".ready"}, 32'(o_ready), 32'(q.size() < DEPTH));
      chk({tag, ".data"}, 32'(o_data_out), 32'(m_head()));
`ifdef LAKE_IN_FIFO_COUNT_EN
      chk({tag, ".count"}, 32'(o_count), 32'(q.size()));
`endif
   endtask

   // One clock: apply inputs, check pre-edge flags, clock, update model, check.
   task automatic step(input string tag, input logic v,
                       input logic [DW-1:0] d, input logic r,
                       input logic f);
      bit do_push;
      bit do_pop;
      i_valid = v;
      i_data_in = d;
      i_ready = r;
      flush = f;
      #1;
      chk({tag, ".pre_ready"}, 32'(o_ready), 32'(q.size() < DEPTH));
      chk({tag, ".pre_data"}, 32'(o_data_out), 32'(m_head()));
      do_push = v && (q.size() < DEPTH);
      do_pop = r && (q.size() > 0);
      @(posedge clk);
      #1;
      if (f) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      check_all(tag);
   endtask

   initial begin
      logic [DW-1:0] d;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data_in = '0;

      // Reset then idle
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;
      step("idle", 1'b0, 2'b00, 1'b0, 1'b0);

      // Fill with consumer stalled, then drain
      step("fill0", 1'b1, 2'b01, 1'b0, 1'b0);
      step("fill1", 1'b1, 2'b10, 1'b0, 1'b0);
      step("fill2", 1'b1, 2'b11, 1'b0, 1'b0);
      step("fill3", 1'b1, 2'b00, 1'b0, 1'b0);
      chk("full_ready", 32'(o_ready), 32'(0));
      step("hold", 1'b0, 2'b00, 1'b0, 1'b0);
      chk("hold_data", 32'(o_data_out), 32'(2'b01));
      for (int i = 0; i < 5; i++) begin
         step("drain", 1'b0, 2'b00, 1'b1, 1'b0);
      end
      chk("drained_valid", 32'(o_valid), 32'(0));

      // Full with push and pop together: pop only
      for (int i = 0; i < DEPTH; i++) begin
         step("refill", 1'b1, DW'(i), 1'b0, 1'b0);
      end
      step("full_pp", 1'b1, 2'b11, 1'b1, 1'b0);
      chk("full_pp_ready", 32'(o_ready), 32'(1));
      for (int i = 0; i < 4; i++) begin
         step("drain2", 1'b0, 2'b00, 1'b1, 1'b0);
      end

      // Streaming
      for (int i = 0; i < 10; i++) begin
         step("stream", 1'b1, DW'(i), 1'b1, 1'b0);
      end
      step("stream_end", 1'b0, 2'b00, 1'b1, 1'b0);

      // Flush with push and pop asserted
      step("pf0", 1'b1, 2'b01, 1'b0, 1'b0);
      step("pf1", 1'b1, 2'b11, 1'b0, 1'b0);
      step("pf2", 1'b1, 2'b00, 1'b0, 1'b0);
      step("flush", 1'b1, 2'b01, 1'b1, 1'b1);
      chk("flush_valid", 32'(o_valid), 32'(0));
      step("post_flush", 1'b1, 2'b10, 1'b0, 1'b0);
      chk("post_flush_data", 32'(o_data_out), 32'(2'b10));
      step("pf_pop", 1'b0, 2'b00, 1'b1, 1'b0);

      // Asynchronous reset between edges
      step("ar0", 1'b1, 2'b10, 1'b0, 1'b0);
      step("ar1", 1'b1, 2'b01, 1'b0, 1'b0);
      i_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(o_valid), 32'(0));
      chk("async_ready", 32'(o_ready), 32'(1));
      q.delete();
      @(posedge clk);
      #1;
      check_all("in_reset");
      rst_n = 1'b1;
      step("ar_push", 1'b1, 2'b11, 1'b0, 1'b0);
      step("ar_pop", 1'b0, 2'b00, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         d = DW'($urandom_range(0, 3));
         step("rand", 1'($urandom_range(0, 1)), d,
              1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
